// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - frame collection and butterfly sequencing for a 16-point radix-2 DIF FFT
//
// Collects FIR samples into a two-bank ping-pong buffer. Each full bank is processed as
// 4 stages of 8 butterflies, with a BF_LAT-cycle drain after every stage.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   fir_valid                 incoming sample strobe
//   wr_en, wr_bank, wr_addr   sample buffer write port
//   bf_start, bf_bank,
//   bf_addr_a, bf_addr_b,
//   bf_tw, bf_stage           butterfly command
//   fft_valid, out_bank       frame-complete pulse and the bank holding the result
//   busy, overrun             compute active, sticky sample-drop flag
module fft_frame_scheduler #(
   parameter int BF_LAT = 2,
   parameter int NPT    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fir_valid,
   output logic       wr_en,
   output logic       wr_bank,
   output logic [3:0] wr_addr,
   output logic       bf_start,
   output logic       bf_bank,
   output logic [3:0] bf_addr_a,
   output logic [3:0] bf_addr_b,
   output logic [2:0] bf_tw,
   output logic [1:0] bf_stage,
   output logic       fft_valid,
   output logic       out_bank,
   output logic       busy,
   output logic       overrun
);
   localparam logic [3:0] LAST_IDX   = 4'(NPT - 1);
   localparam logic [2:0] ISSUE_LAST = 3'd7;
   localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] stage_q, stage_d;
   logic       bf_bank_q, bf_bank_d;
   logic       nxt_bank_q, nxt_bank_d;
   logic [1:0] full_q, full_d;
   logic       wr_bank_q, wr_bank_d;
   logic [3:0] wr_addr_q, wr_addr_d;
   logic       overrun_q, overrun_d;

   logic done, wr_free, wr_last, nxt_ready;

   assign done    = (state_q == S_DONE);
   // The bank released by DONE may be written in that same cycle.
   assign wr_free = ~full_q[wr_bank_q] | (done & (bf_bank_q == wr_bank_q));
   assign wr_en   = rst & fir_valid & wr_free;
   assign wr_last = wr_en & (wr_addr_q == LAST_IDX);
   // Banks fill and drain in strict alternation, so the next bank to compute is
   // always the oldest full one. A frame completing this cycle counts as full.
   assign nxt_ready = full_q[nxt_bank_q] | (wr_last & (wr_bank_q == nxt_bank_q));

   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q ^ wr_last;
      wr_addr_d = wr_addr_q;
      overrun_d = overrun_q | (fir_valid & ~wr_free);
      if (done) full_d[bf_bank_q] = 1'b0;
      if (wr_last) full_d[wr_bank_q] = 1'b1;
      if (!fir_valid) wr_addr_d = 4'd0;
      else if (wr_en) wr_addr_d = wr_addr_q + 4'd1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stage_d    = stage_q;
      bf_bank_d  = bf_bank_q;
      nxt_bank_d = nxt_bank_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            stage_d = 2'd0;
            cnt_d   = 3'd0;
            state_d = S_IDLE;
            if (nxt_ready) begin
               state_d    = S_ISSUE;
               bf_bank_d  = nxt_bank_q;
               nxt_bank_d = ~nxt_bank_q;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == ISSUE_LAST) begin
               cnt_d   = 3'd0;
               state_d = S_DRAIN;
            end
         end
         default: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == DRAIN_LAST) begin
               cnt_d = 3'd0;
               if (stage_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  stage_d = stage_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end
         end
      endcase
   end

   // Operand indices: the span bit (8>>stage) separates a from b, the bits above it are
   // the group and the bits below are the position within the group.
   always_comb begin
      bf_addr_a = 4'd0;
      bf_addr_b = 4'd0;
      bf_tw     = 3'd0;
      if (state_q == S_ISSUE) begin
         case (stage_q)
            2'd0: begin
               bf_addr_a = {1'b0, cnt_q};
               bf_addr_b = {1'b1, cnt_q};
               bf_tw     = cnt_q;
            end
            2'd1: begin
               bf_addr_a = {cnt_q[2], 1'b0, cnt_q[1:0]};
               bf_addr_b = {cnt_q[2], 1'b1, cnt_q[1:0]};
               bf_tw     = {cnt_q[1:0], 1'b0};
            end
            2'd2: begin
               bf_addr_a = {cnt_q[2:1], 1'b0, cnt_q[0]};
               bf_addr_b = {cnt_q[2:1], 1'b1, cnt_q[0]};
               bf_tw     = {cnt_q[0], 2'b00};
            end
            default: begin
               bf_addr_a = {cnt_q, 1'b0};
               bf_addr_b = {cnt_q, 1'b1};
               bf_tw     = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         stage_q    <= 2'd0;
         bf_bank_q  <= 1'b0;
         nxt_bank_q <= 1'b0;
         full_q     <= 2'b00;
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= 4'd0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stage_q    <= stage_d;
         bf_bank_q  <= bf_bank_d;
         nxt_bank_q <= nxt_bank_d;
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         wr_addr_q  <= wr_addr_d;
         overrun_q  <= overrun_d;
      end
   end

   assign wr_bank   = wr_bank_q;
   assign wr_addr   = wr_addr_q;
   assign bf_start  = (state_q == S_ISSUE);
   assign bf_bank   = bf_bank_q;
   assign bf_stage  = stage_q;
   assign fft_valid = done;
   assign out_bank  = done & bf_bank_q;
   assign busy      = (state_q != S_IDLE);
   assign overrun   = overrun_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - self-checking bench for fft_frame_scheduler (BF_LAT 2 and 7)
module tb_fft_frame_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] fv = 2'b00;
   logic [1:0] wr_en_w, wr_bank_w, bf_start_w, bf_bank_w, fftv_w, ob_w, busy_w, ovr_w;
   logic [1:0][3:0] wr_addr_w, bfa_w, bfb_w;
   logic [1:0][2:0] tw_w;
   logic [1:0][1:0] st_w;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int vlog0[$];
   int vlog1[$];
   int lat[2];

   // reference model state, one slot per DUT
   int m_full[2][2];
   int m_wbank[2], m_waddr[2], m_ovr[2], m_busy[2], m_bank[2], m_tstart[2], m_next[2];

   // monitor scratch
   int P, rel, stg, k, span, ea, eb, etw;
   bit e_done, e_iss, e_free, e_wren, e_last;
   logic [5:0]  e_w;
   logic [10:0] e_cmd;
   logic [3:0]  e_st;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft_frame_scheduler #(.BF_LAT(2), .NPT(16)) u_dut2 (
      .clk(clk), .rst(rst), .fir_valid(fv[0]),
      .wr_en(wr_en_w[0]), .wr_bank(wr_bank_w[0]), .wr_addr(wr_addr_w[0]),
      .bf_start(bf_start_w[0]), .bf_bank(bf_bank_w[0]), .bf_addr_a(bfa_w[0]), .bf_addr_b(bfb_w[0]),
      .bf_tw(tw_w[0]), .bf_stage(st_w[0]), .fft_valid(fftv_w[0]), .out_bank(ob_w[0]),
      .busy(busy_w[0]), .overrun(ovr_w[0]));

   fft_frame_scheduler #(.BF_LAT(7), .NPT(16)) u_dut7 (
      .clk(clk), .rst(rst), .fir_valid(fv[1]),
      .wr_en(wr_en_w[1]), .wr_bank(wr_bank_w[1]), .wr_addr(wr_addr_w[1]),
      .bf_start(bf_start_w[1]), .bf_bank(bf_bank_w[1]), .bf_addr_a(bfa_w[1]), .bf_addr_b(bfb_w[1]),
      .bf_tw(tw_w[1]), .bf_stage(st_w[1]), .fft_valid(fftv_w[1]), .out_bank(ob_w[1]),
      .busy(busy_w[1]), .overrun(ovr_w[1]));

   function automatic logic [24:0] outs(input int d);
      return {wr_en_w[d], wr_bank_w[d], wr_addr_w[d], bf_start_w[d], bf_bank_w[d], bfa_w[d],
              bfb_w[d], tw_w[d], st_w[d], fftv_w[d], ob_w[d], busy_w[d], ovr_w[d]};
   endfunction

   function automatic void model_reset(input int d);
      m_full[d][0] = 0; m_full[d][1] = 0;
      m_wbank[d] = 0; m_waddr[d] = 0; m_ovr[d] = 0; m_busy[d] = 0;
      m_bank[d] = 0; m_tstart[d] = 0; m_next[d] = 0;
   endfunction

   // Cycle-by-cycle scoreboard. A compute job is a time window starting at m_tstart:
   // stage s issues in [s*P, s*P+8), completion lands at 4*P.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            n_checks++;
            if (outs(d) !== 25'd0) begin
               n_errors++;
               $display("FAIL reset_outputs dut%0d cycle %0d: got %h expected 0", d, cyc, outs(d));
            end
            model_reset(d);
         end else begin
            P      = 8 + lat[d];
            rel    = cyc - m_tstart[d];
            e_done = (m_busy[d] != 0) && (rel == 4 * P);
            e_iss  = (m_busy[d] != 0) && (rel < 4 * P) && ((rel % P) < 8);
            stg    = rel / P;
            k      = rel % P;
            e_free = (m_full[d][m_wbank[d]] == 0) || (e_done && m_bank[d] == m_wbank[d]);
            e_wren = fv[d] && e_free;

            e_w = {e_wren, 1'(m_wbank[d]), 4'(m_waddr[d])};
            n_checks++;
            if ({wr_en_w[d], wr_bank_w[d], wr_addr_w[d]} !== e_w) begin
               n_errors++;
               $display("FAIL writer dut%0d cycle %0d: got %b expected %b", d, cyc,
                        {wr_en_w[d], wr_bank_w[d], wr_addr_w[d]}, e_w);
            end
            n_checks++;
            if (bf_start_w[d] !== e_iss) begin
               n_errors++;
               $display("FAIL bf_start dut%0d cycle %0d: got %b expected %b", d, cyc, bf_start_w[d], e_iss);
            end
            if (e_iss) begin
               span  = 8 >> stg;
               ea    = (k / span) * 2 * span + (k % span);
               eb    = ea + span;
               etw   = ((k % span) << stg) % 8;
               e_cmd = {2'(stg), 4'(ea), 4'(eb), 1'b0};
               n_checks++;
               if ({st_w[d], bfa_w[d], bfb_w[d], tw_w[d]} !== {e_cmd[10:1], 3'(etw)}) begin
                  n_errors++;
                  $display("FAIL command dut%0d cycle %0d: got st%0d a%0d b%0d tw%0d expected st%0d a%0d b%0d tw%0d",
                           d, cyc, st_w[d], bfa_w[d], bfb_w[d], tw_w[d], stg, ea, eb, etw);
               end
            end
            if (m_busy[d] != 0) begin
               n_checks++;
               if (bf_bank_w[d] !== 1'(m_bank[d])) begin
                  n_errors++;
                  $display("FAIL bf_bank dut%0d cycle %0d: got %b expected %0d", d, cyc, bf_bank_w[d], m_bank[d]);
               end
            end
            e_st = {e_done, e_done ? 1'(m_bank[d]) : 1'b0, m_busy[d] != 0, m_ovr[d] != 0};
            n_checks++;
            if ({fftv_w[d], ob_w[d], busy_w[d], ovr_w[d]} !== e_st) begin
               n_errors++;
               $display("FAIL status dut%0d cycle %0d: got %b expected %b", d, cyc,
                        {fftv_w[d], ob_w[d], busy_w[d], ovr_w[d]}, e_st);
            end
            if (fftv_w[d] === 1'b1) begin
               if (d == 0) vlog0.push_back(int'(ob_w[d]));
               else        vlog1.push_back(int'(ob_w[d]));
            end

            e_last = e_wren && (m_waddr[d] == 15);
            if (e_done) begin
               m_full[d][m_bank[d]] = 0;
               m_busy[d] = 0;
            end
            if (e_last) begin
               m_full[d][m_wbank[d]] = 1;
               m_wbank[d] = 1 - m_wbank[d];
               m_waddr[d] = 0;
            end else if (e_wren) begin
               m_waddr[d] = m_waddr[d] + 1;
            end else if (!fv[d]) begin
               m_waddr[d] = 0;
            end
            if (fv[d] && !e_free) m_ovr[d] = 1;
            if (m_busy[d] == 0 && m_full[d][m_next[d]] != 0) begin
               m_busy[d]   = 1;
               m_bank[d]   = m_next[d];
               m_next[d]   = 1 - m_next[d];
               m_tstart[d] = cyc + 1;
            end
         end
      end
   end

   task automatic tick(input logic v0, input logic v1);
      @(posedge clk);
      #1;
      fv[0] = v0;
      fv[1] = v1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      fv  = 2'b00;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      vlog0.delete();
      vlog1.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (outs(d) !== 25'd0) begin
            n_errors++;
            $display("FAIL test_reset dut%0d: got %h expected 0", d, outs(d));
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_w[0], ovr_w[0], wr_addr_w[0], wr_en_w[0]} !== 7'd0) begin
         n_errors++;
         $display("FAIL test_reset_release: got %b expected 0", {busy_w[0], ovr_w[0], wr_addr_w[0], wr_en_w[0]});
      end
   endtask

   task automatic test_single_frame();
      int c_last, t_fft, obk;
      int q_cyc[$], q_a[$], q_b[$], q_tw[$], q_st[$];
      do_reset();
      c_last = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, 1'b0);
         n_checks++;
         if ({wr_en_w[0], wr_bank_w[0], wr_addr_w[0]} !== {1'b1, 1'b0, 4'(i)}) begin
            n_errors++;
            $display("FAIL frame_write i=%0d: got en%b bank%b addr%0d expected en1 bank0 addr%0d",
                     i, wr_en_w[0], wr_bank_w[0], wr_addr_w[0], i);
         end
         if (i == 15) c_last = cyc;
      end
      t_fft = -1;
      obk   = -1;
      for (int j = 0; j < 60; j++) begin
         tick(1'b0, 1'b0);
         if (bf_start_w[0] === 1'b1) begin
            q_cyc.push_back(cyc);
            q_a.push_back(int'(bfa_w[0]));
            q_b.push_back(int'(bfb_w[0]));
            q_tw.push_back(int'(tw_w[0]));
            q_st.push_back(int'(st_w[0]));
         end
         if (fftv_w[0] === 1'b1 && t_fft < 0) begin
            t_fft = cyc;
            obk   = int'(ob_w[0]);
         end
      end
      n_checks++;
      if (q_cyc.size() != 32) begin
         n_errors++;
         $display("FAIL bf_count: got %0d expected 32", q_cyc.size());
      end
      n_checks++;
      if (t_fft != c_last + 41) begin
         n_errors++;
         $display("FAIL fft_latency: got %0d expected %0d", t_fft - c_last, 41);
      end
      n_checks++;
      if (obk != 0) begin
         n_errors++;
         $display("FAIL out_bank: got %0d expected 0", obk);
      end
      if (q_cyc.size() == 32) begin
         n_checks++;
         if (q_cyc[0] != c_last + 1) begin
            n_errors++;
            $display("FAIL first_bf: got +%0d expected +1", q_cyc[0] - c_last);
         end
         for (int kk = 0; kk < 8; kk++) begin
            n_checks++;
            if (q_a[kk] != kk || q_b[kk] != kk + 8 || q_tw[kk] != kk || q_st[kk] != 0) begin
               n_errors++;
               $display("FAIL stage0 k=%0d: got a%0d b%0d tw%0d expected a%0d b%0d tw%0d",
                        kk, q_a[kk], q_b[kk], q_tw[kk], kk, kk + 8, kk);
            end
            n_checks++;
            if (q_a[24 + kk] != 2 * kk || q_b[24 + kk] != 2 * kk + 1 || q_tw[24 + kk] != 0 || q_st[24 + kk] != 3) begin
               n_errors++;
               $display("FAIL stage3 k=%0d: got a%0d b%0d tw%0d expected a%0d b%0d tw0",
                        kk, q_a[24 + kk], q_b[24 + kk], q_tw[24 + kk], 2 * kk, 2 * kk + 1);
            end
         end
         n_checks++;
         if (q_a[13] != 9 || q_b[13] != 13 || q_tw[13] != 2) begin
            n_errors++;
            $display("FAIL stage1_k5: got a%0d b%0d tw%0d expected a9 b13 tw2", q_a[13], q_b[13], q_tw[13]);
         end
         for (int s = 1; s < 4; s++) begin
            n_checks++;
            if (q_cyc[8 * s] - q_cyc[8 * s - 1] != 3) begin
               n_errors++;
               $display("FAIL stage_gap s=%0d: got %0d expected 3", s, q_cyc[8 * s] - q_cyc[8 * s - 1]);
            end
         end
      end
   endtask

   task automatic test_stream_gapped();
      int to;
      do_reset();
      repeat (32) tick(1'b1, 1'b0);
      to = 0;
      while (vlog0.size() < 1 && to < 100) begin
         tick(1'b0, 1'b0);
         to++;
      end
      n_checks++;
      if (vlog0.size() < 1) begin
         n_errors++;
         $display("FAIL stream_first_done: got %0d frames expected 1 (timeout)", vlog0.size());
      end
      repeat (16) tick(1'b1, 1'b0);
      to = 0;
      while ((vlog0.size() < 3 || busy_w[0] !== 1'b0) && to < 300) begin
         tick(1'b0, 1'b0);
         to++;
      end
      n_checks++;
      if (vlog0.size() != 3) begin
         n_errors++;
         $display("FAIL stream_frames: got %0d expected 3", vlog0.size());
      end else begin
         n_checks++;
         if (vlog0[0] != 0 || vlog0[1] != 1 || vlog0[2] != 0) begin
            n_errors++;
            $display("FAIL stream_banks: got %0d%0d%0d expected 010", vlog0[0], vlog0[1], vlog0[2]);
         end
      end
      n_checks++;
      if (ovr_w[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL stream_overrun: got %b expected 0", ovr_w[0]);
      end
   endtask

   task automatic test_overrun();
      int drops, to;
      do_reset();
      drops = 0;
      for (int i = 0; i < 48; i++) begin
         tick(1'b0, 1'b1);
         if (wr_en_w[1] !== 1'b1) drops++;
      end
      n_checks++;
      if (drops != 16) begin
         n_errors++;
         $display("FAIL overrun_drops: got %0d expected 16", drops);
      end
      to = 0;
      while ((vlog1.size() < 2 || busy_w[1] !== 1'b0) && to < 300) begin
         tick(1'b0, 1'b0);
         to++;
      end
      n_checks++;
      if (vlog1.size() != 2) begin
         n_errors++;
         $display("FAIL overrun_frames: got %0d expected 2", vlog1.size());
      end else begin
         n_checks++;
         if (vlog1[0] != 0 || vlog1[1] != 1) begin
            n_errors++;
            $display("FAIL overrun_banks: got %0d%0d expected 01", vlog1[0], vlog1[1]);
         end
      end
      n_checks++;
      if (ovr_w[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL overrun_sticky: got %b expected 1", ovr_w[1]);
      end
   endtask

   task automatic test_partial();
      do_reset();
      repeat (10) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      n_checks++;
      if ({wr_en_w[0], wr_bank_w[0], wr_addr_w[0]} !== 6'b100000) begin
         n_errors++;
         $display("FAIL partial_restart: got en%b bank%b addr%0d expected en1 bank0 addr0",
                  wr_en_w[0], wr_bank_w[0], wr_addr_w[0]);
      end
      repeat (15) tick(1'b1, 1'b0);
      repeat (80) tick(1'b0, 1'b0);
      n_checks++;
      if (vlog0.size() != 1 || (vlog0.size() == 1 && vlog0[0] != 0)) begin
         n_errors++;
         $display("FAIL partial_frames: got %0d frames expected 1 on bank 0", vlog0.size());
      end
   endtask

   task automatic test_mid_reset();
      int to;
      do_reset();
      repeat (16) tick(1'b1, 1'b0);
      to = 0;
      while (!(bf_start_w[0] === 1'b1 && st_w[0] === 2'd2) && to < 60) begin
         tick(1'b0, 1'b0);
         to++;
      end
      n_checks++;
      if (to >= 60) begin
         n_errors++;
         $display("FAIL mid_reset_reach_stage2: got timeout expected stage 2 issue");
      end
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (outs(0) !== 25'd0) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got %h expected 0", outs(0));
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      vlog0.delete();
      repeat (60) tick(1'b0, 1'b0);
      n_checks++;
      if (vlog0.size() != 0) begin
         n_errors++;
         $display("FAIL mid_reset_no_valid: got %0d expected 0", vlog0.size());
      end
      repeat (16) tick(1'b1, 1'b0);
      repeat (60) tick(1'b0, 1'b0);
      n_checks++;
      if (vlog0.size() != 1 || (vlog0.size() == 1 && vlog0[0] != 0)) begin
         n_errors++;
         $display("FAIL mid_reset_new_frame: got %0d frames expected 1 on bank 0", vlog0.size());
      end
   endtask

   initial begin
      lat[0] = 2;
      lat[1] = 7;
      #1;
      rst = 1'b0;
      test_reset();
      test_single_frame();
      test_stream_gapped();
      test_overrun();
      test_partial();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
